// File: rtl/ysyx_23060184_bus_arbiter_pkg.sv
// Shared definitions for the IFU/LSU bus arbiter: FSM states, AXI response codes,
// SRAM window bounds and grant bit positions.
package ysyx_23060184_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrResp,
    StErrResp
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [31:0] SramBase  = 32'h8000_0000;
  localparam logic [31:0] SramLimit = 32'h8800_0000;

  localparam int unsigned GntIfu = 0;
  localparam int unsigned GntLsu = 1;

endpackage

// File: rtl/ysyx_23060184_addr_decode.sv
// Combinational address decoder: classifies an address as SRAM, UART or unmapped.
module ysyx_23060184_addr_decode
  import ysyx_23060184_bus_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [DATA_WIDTH-1:0] UART_SIZE  = 32'h8
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic                  sram_o,
  output logic                  uart_o,
  output logic                  err_o
);

  logic [DATA_WIDTH-1:0] uart_off;

  // Offset compare avoids overflow of UART_BASE + UART_SIZE at the top of the map.
  assign uart_off = addr_i - UART_BASE;
  assign uart_o   = (addr_i >= UART_BASE) && (uart_off < UART_SIZE);
  assign sram_o   = (addr_i >= DATA_WIDTH'(SramBase)) && (addr_i < DATA_WIDTH'(SramLimit));
  assign err_o    = !sram_o && !uart_o;

endmodule

// File: rtl/ysyx_23060184_bus_arbiter.sv
// Round-robin AXI4-lite arbiter between IFU (read only) and LSU, routing each
// transaction to SRAM or UART, with DECERR for unmapped addresses.
module ysyx_23060184_bus_arbiter
  import ysyx_23060184_bus_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] UART_BASE  = 32'ha000_03f8,
  parameter logic [DATA_WIDTH-1:0] UART_SIZE  = 32'h8
) (
  input  logic                    clk,
  input  logic                    reset,
  // IFU
  input  logic [DATA_WIDTH-1:0]   i_araddr,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic [1:0]              i_rresp,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  // LSU
  input  logic [DATA_WIDTH-1:0]   d_araddr,
  input  logic                    d_arvalid,
  output logic                    d_arready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [1:0]              d_rresp,
  output logic                    d_rvalid,
  input  logic                    d_rready,
  input  logic [DATA_WIDTH-1:0]   d_awaddr,
  input  logic                    d_awvalid,
  output logic                    d_awready,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  input  logic                    d_wvalid,
  output logic                    d_wready,
  output logic [1:0]              d_bresp,
  output logic                    d_bvalid,
  input  logic                    d_bready,
  // SRAM
  output logic [DATA_WIDTH-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready,
  // UART
  output logic [DATA_WIDTH-1:0]   u_araddr,
  output logic                    u_arvalid,
  input  logic                    u_arready,
  input  logic [DATA_WIDTH-1:0]   u_rdata,
  input  logic [1:0]              u_rresp,
  input  logic                    u_rvalid,
  output logic                    u_rready,
  output logic [DATA_WIDTH-1:0]   u_awaddr,
  output logic                    u_awvalid,
  input  logic                    u_awready,
  output logic [DATA_WIDTH-1:0]   u_wdata,
  output logic [DATA_WIDTH/8-1:0] u_wstrb,
  output logic                    u_wvalid,
  input  logic                    u_wready,
  input  logic [1:0]              u_bresp,
  input  logic                    u_bvalid,
  output logic                    u_bready,
  output logic [1:0]              grant
);

  state_e     state_q;
  logic [1:0] grant_q;
  logic       last_lsu_q, sel_uart_q, wr_q, aw_done_q, w_done_q, err_ph_q;

  logic                  req_ifu, req_lsu_wr, req_lsu, win_lsu, owner_lsu;
  logic [DATA_WIDTH-1:0] rd_addr;
  logic                  own_arvalid, own_rready;
  logic                  rd_sram, rd_uart, rd_err, rd_bad;
  logic                  wr_sram, wr_uart, wr_err;
  logic                  slv_arready, slv_rvalid, slv_awready, slv_wready, slv_bvalid;
  logic [DATA_WIDTH-1:0] slv_rdata;
  logic [1:0]            slv_rresp, slv_bresp;
  logic                  aw_fire, w_fire, aw_vld, w_vld;
  logic                  own_arready, own_rvalid;
  logic [DATA_WIDTH-1:0] own_rdata;
  logic [1:0]            own_rresp;

  // An LSU write needs both address and data valid; it outranks an LSU read.
  assign req_ifu    = i_arvalid;
  assign req_lsu_wr = d_awvalid && d_wvalid;
  assign req_lsu    = req_lsu_wr || d_arvalid;
  assign win_lsu    = req_lsu && (!req_ifu || !last_lsu_q);
  assign owner_lsu  = (state_q == StIdle) ? win_lsu : grant_q[GntLsu];

  assign rd_addr     = owner_lsu ? d_araddr  : i_araddr;
  assign own_arvalid = owner_lsu ? d_arvalid : i_arvalid;
  assign own_rready  = owner_lsu ? d_rready  : i_rready;
  assign rd_bad      = rd_err || (rd_uart && !owner_lsu);

  ysyx_23060184_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .UART_BASE (UART_BASE),
    .UART_SIZE (UART_SIZE)
  ) u_rd_decode (
    .addr_i(rd_addr),
    .sram_o(rd_sram),
    .uart_o(rd_uart),
    .err_o (rd_err)
  );

  ysyx_23060184_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .UART_BASE (UART_BASE),
    .UART_SIZE (UART_SIZE)
  ) u_wr_decode (
    .addr_i(d_awaddr),
    .sram_o(wr_sram),
    .uart_o(wr_uart),
    .err_o (wr_err)
  );

  assign slv_arready = sel_uart_q ? u_arready : s_arready;
  assign slv_rvalid  = sel_uart_q ? u_rvalid  : s_rvalid;
  assign slv_rdata   = sel_uart_q ? u_rdata   : s_rdata;
  assign slv_rresp   = sel_uart_q ? u_rresp   : s_rresp;
  assign slv_awready = sel_uart_q ? u_awready : s_awready;
  assign slv_wready  = sel_uart_q ? u_wready  : s_wready;
  assign slv_bvalid  = sel_uart_q ? u_bvalid  : s_bvalid;
  assign slv_bresp   = sel_uart_q ? u_bresp   : s_bresp;

  assign aw_vld  = !aw_done_q && d_awvalid;
  assign w_vld   = !w_done_q && d_wvalid;
  assign aw_fire = aw_vld && slv_awready;
  assign w_fire  = w_vld && slv_wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_lsu_q <= 1'b0;
      sel_uart_q <= 1'b0;
      wr_q       <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_ph_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_ifu || req_lsu) begin
            grant_q    <= win_lsu ? 2'b10 : 2'b01;
            last_lsu_q <= win_lsu;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            err_ph_q   <= 1'b0;
            if (win_lsu && req_lsu_wr) begin
              wr_q       <= 1'b1;
              sel_uart_q <= wr_uart && !wr_sram;
              state_q    <= wr_err ? StErrResp : StWrAddr;
            end else begin
              wr_q       <= 1'b0;
              sel_uart_q <= rd_uart && !rd_sram;
              state_q    <= rd_bad ? StErrResp : StRdAddr;
            end
          end
        end
        StRdAddr: begin
          if (own_arvalid && slv_arready) begin
            state_q <= StRdData;
          end else if (!own_arvalid) begin
            // Master withdrew its request; give the bus back rather than hang.
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        StRdData: begin
          if (slv_rvalid && own_rready) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        StWrAddr: begin
          if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
            state_q <= StWrResp;
          end else if ((!aw_done_q && !d_awvalid) || (!w_done_q && !d_wvalid)) begin
            state_q <= StIdle;
            grant_q <= '0;
          end else begin
            aw_done_q <= aw_done_q || aw_fire;
            w_done_q  <= w_done_q || w_fire;
          end
        end
        StWrResp: begin
          if (slv_bvalid && d_bready) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        StErrResp: begin
          if (!err_ph_q) begin
            err_ph_q <= 1'b1;
          end else if (wr_q ? d_bready : own_rready) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    u_araddr = '0; u_arvalid = 1'b0; u_rready = 1'b0;
    u_awaddr = '0; u_awvalid = 1'b0; u_wdata = '0; u_wstrb = '0; u_wvalid = 1'b0;
    u_bready = 1'b0;
    own_arready = 1'b0; own_rvalid = 1'b0; own_rdata = '0; own_rresp = RespOkay;
    d_awready = 1'b0; d_wready = 1'b0; d_bvalid = 1'b0; d_bresp = RespOkay;
    unique case (state_q)
      StRdAddr: begin
        own_arready = slv_arready;
        if (sel_uart_q) begin
          u_arvalid = own_arvalid;
          u_araddr  = rd_addr;
        end else begin
          s_arvalid = own_arvalid;
          s_araddr  = rd_addr;
        end
      end
      StRdData: begin
        own_rvalid = slv_rvalid;
        own_rdata  = slv_rdata;
        own_rresp  = slv_rresp;
        if (sel_uart_q) u_rready = own_rready;
        else            s_rready = own_rready;
      end
      StWrAddr: begin
        d_awready = !aw_done_q && slv_awready;
        d_wready  = !w_done_q && slv_wready;
        if (sel_uart_q) begin
          u_awvalid = aw_vld; u_awaddr = d_awaddr;
          u_wvalid  = w_vld;  u_wdata  = d_wdata;  u_wstrb = d_wstrb;
        end else begin
          s_awvalid = aw_vld; s_awaddr = d_awaddr;
          s_wvalid  = w_vld;  s_wdata  = d_wdata;  s_wstrb = d_wstrb;
        end
      end
      StWrResp: begin
        d_bvalid = slv_bvalid;
        d_bresp  = slv_bresp;
        if (sel_uart_q) u_bready = d_bready;
        else            s_bready = d_bready;
      end
      StErrResp: begin
        if (!err_ph_q) begin
          if (wr_q) begin
            d_awready = 1'b1;
            d_wready  = 1'b1;
          end else begin
            own_arready = 1'b1;
          end
        end else if (wr_q) begin
          d_bvalid = 1'b1;
          d_bresp  = RespDecerr;
        end else begin
          own_rvalid = 1'b1;
          own_rresp  = RespDecerr;
        end
      end
      default: ;
    endcase
  end

  assign i_arready = !owner_lsu && own_arready;
  assign d_arready = owner_lsu && own_arready;
  assign i_rvalid  = !owner_lsu && own_rvalid;
  assign d_rvalid  = owner_lsu && own_rvalid;
  assign i_rdata   = owner_lsu ? '0 : own_rdata;
  assign d_rdata   = owner_lsu ? own_rdata : '0;
  assign i_rresp   = owner_lsu ? RespOkay : own_rresp;
  assign d_rresp   = owner_lsu ? own_rresp : RespOkay;
  assign grant     = grant_q;

endmodule

// File: tb/tb_ysyx_23060184_bus_arbiter.sv
// Directed bench for the IFU/LSU bus arbiter with hand-driven SRAM/UART slaves.
module tb_ysyx_23060184_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_araddr, i_rdata, d_araddr, d_rdata, d_awaddr, d_wdata;
  logic        i_arvalid, i_arready, i_rvalid, i_rready;
  logic [1:0]  i_rresp, d_rresp, d_bresp, s_rresp, s_bresp, u_rresp, u_bresp, grant;
  logic        d_arvalid, d_arready, d_rvalid, d_rready, d_awvalid, d_awready;
  logic [3:0]  d_wstrb, s_wstrb, u_wstrb;
  logic        d_wvalid, d_wready, d_bvalid, d_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata, u_araddr, u_rdata, u_awaddr, u_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;
  logic        u_arvalid, u_arready, u_rvalid, u_rready, u_awvalid, u_awready;
  logic        u_wvalid, u_wready, u_bvalid, u_bready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_23060184_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .u_araddr(u_araddr), .u_arvalid(u_arvalid), .u_arready(u_arready),
    .u_rdata(u_rdata), .u_rresp(u_rresp), .u_rvalid(u_rvalid), .u_rready(u_rready),
    .u_awaddr(u_awaddr), .u_awvalid(u_awvalid), .u_awready(u_awready),
    .u_wdata(u_wdata), .u_wstrb(u_wstrb), .u_wvalid(u_wvalid), .u_wready(u_wready),
    .u_bresp(u_bresp), .u_bvalid(u_bvalid), .u_bready(u_bready),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    i_araddr = '0; i_arvalid = 0; i_rready = 0;
    d_araddr = '0; d_arvalid = 0; d_rready = 0;
    d_awaddr = '0; d_awvalid = 0; d_wdata = '0; d_wstrb = '0; d_wvalid = 0; d_bready = 0;
    s_arready = 0; s_rdata = '0; s_rresp = 0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = 0; s_bvalid = 0;
    u_arready = 0; u_rdata = '0; u_rresp = 0; u_rvalid = 0;
    u_awready = 0; u_wready = 0; u_bresp = 0; u_bvalid = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_arvalid", 32'(s_arvalid), 32'h0);
    chk("rst_i_arready", 32'(i_arready), 32'h0);

    // IFU read from SRAM
    i_arvalid = 1; i_araddr = 32'h8000_0000;
    #1 chk("ifu_idle_grant", 32'(grant), 32'h0);
    tick();
    #1 chk("ifu_grant", 32'(grant), 32'h1);
    chk("ifu_s_arvalid", 32'(s_arvalid), 32'h1);
    chk("ifu_s_araddr", s_araddr, 32'h8000_0000);
    chk("ifu_u_arvalid", 32'(u_arvalid), 32'h0);
    chk("ifu_arready_wait", 32'(i_arready), 32'h0);
    s_arready = 1;
    #1 chk("ifu_arready", 32'(i_arready), 32'h1);
    tick();
    i_arvalid = 0; s_arready = 0;
    s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00; i_rready = 1;
    #1 chk("ifu_rvalid", 32'(i_rvalid), 32'h1);
    chk("ifu_rdata", i_rdata, 32'h0000_0413);
    chk("ifu_rresp", 32'(i_rresp), 32'h0);
    chk("ifu_s_rready", 32'(s_rready), 32'h1);
    tick();
    s_rvalid = 0; i_rready = 0;
    #1 chk("ifu_back_idle", 32'(grant), 32'h0);

    // Simultaneous requests: LSU first, then IFU, then LSU again
    i_arvalid = 1; i_araddr = 32'h8000_0004;
    d_arvalid = 1; d_araddr = 32'h8000_0008;
    tick();
    #1 chk("rr1_grant", 32'(grant), 32'h2);
    chk("rr1_s_araddr", s_araddr, 32'h8000_0008);
    chk("rr1_i_arready", 32'(i_arready), 32'h0);
    s_arready = 1;
    tick();
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_aaaa; d_rready = 1;
    #1 chk("rr1_d_rdata", d_rdata, 32'h0000_aaaa);
    chk("rr1_i_rvalid", 32'(i_rvalid), 32'h0);
    tick();
    s_rvalid = 0; d_rready = 0; d_araddr = 32'h8000_0010;
    tick();
    #1 chk("rr2_grant", 32'(grant), 32'h1);
    chk("rr2_s_araddr", s_araddr, 32'h8000_0004);
    chk("rr2_d_arready", 32'(d_arready), 32'h0);
    s_arready = 1;
    tick();
    s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_bbbb; i_rready = 1;
    i_araddr = 32'h8000_000c;
    #1 chk("rr2_i_rdata", i_rdata, 32'h0000_bbbb);
    tick();
    s_rvalid = 0; i_rready = 0;
    tick();
    #1 chk("rr3_grant", 32'(grant), 32'h2);
    chk("rr3_s_araddr", s_araddr, 32'h8000_0010);
    s_arready = 1;
    tick();
    // SRAM holds rvalid while LSU stalls; pending IFU must wait
    s_arready = 0; d_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_cccc; d_rready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_grant", 32'(grant), 32'h2);
      chk("stall_d_rvalid", 32'(d_rvalid), 32'h1);
      chk("stall_i_arready", 32'(i_arready), 32'h0);
      chk("stall_s_arvalid", 32'(s_arvalid), 32'h0);
      tick();
    end
    d_rready = 1;
    #1 chk("stall_d_rdata", d_rdata, 32'h0000_cccc);
    tick();
    s_rvalid = 0; d_rready = 0;
    #1 chk("stall_idle", 32'(grant), 32'h0);
    tick();
    #1 chk("stall_ifu_grant", 32'(grant), 32'h1);
    chk("stall_ifu_addr", s_araddr, 32'h8000_000c);
    s_arready = 1;
    tick();
    i_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_dddd; i_rready = 1;
    tick();
    s_rvalid = 0; i_rready = 0;

    // LSU write to UART
    d_awvalid = 1; d_awaddr = 32'ha000_03f8; d_wvalid = 1; d_wdata = 32'h41; d_wstrb = 4'b0001;
    tick();
    #1 chk("uw_grant", 32'(grant), 32'h2);
    chk("uw_u_awvalid", 32'(u_awvalid), 32'h1);
    chk("uw_u_wvalid", 32'(u_wvalid), 32'h1);
    chk("uw_u_awaddr", u_awaddr, 32'ha000_03f8);
    chk("uw_u_wdata", u_wdata, 32'h41);
    chk("uw_u_wstrb", 32'(u_wstrb), 32'h1);
    chk("uw_s_awvalid", 32'(s_awvalid), 32'h0);
    chk("uw_s_wvalid", 32'(s_wvalid), 32'h0);
    chk("uw_s_awaddr", s_awaddr, 32'h0);
    u_awready = 1;
    #1 chk("uw_d_awready", 32'(d_awready), 32'h1);
    chk("uw_d_wready", 32'(d_wready), 32'h0);
    tick();
    d_awvalid = 0; u_awready = 0;
    #1 chk("uw_aw_dropped", 32'(u_awvalid), 32'h0);
    chk("uw_w_held", 32'(u_wvalid), 32'h1);
    u_wready = 1;
    tick();
    d_wvalid = 0; u_wready = 0; u_bvalid = 1; u_bresp = 2'b00; d_bready = 1;
    #1 chk("uw_d_bvalid", 32'(d_bvalid), 32'h1);
    chk("uw_d_bresp", 32'(d_bresp), 32'h0);
    chk("uw_u_bready", 32'(u_bready), 32'h1);
    chk("uw_s_bready", 32'(s_bready), 32'h0);
    tick();
    u_bvalid = 0; d_bready = 0;
    #1 chk("uw_idle", 32'(grant), 32'h0);

    // LSU read to unmapped address
    d_arvalid = 1; d_araddr = 32'h0000_1000;
    tick();
    #1 chk("er_d_arready", 32'(d_arready), 32'h1);
    chk("er_s_arvalid", 32'(s_arvalid), 32'h0);
    chk("er_u_arvalid", 32'(u_arvalid), 32'h0);
    tick();
    d_arvalid = 0;
    #1 chk("er_d_rvalid", 32'(d_rvalid), 32'h1);
    chk("er_d_rresp", 32'(d_rresp), 32'h3);
    chk("er_d_rdata", d_rdata, 32'h0);
    tick();
    #1 chk("er_hold", 32'(d_rvalid), 32'h1);
    d_rready = 1;
    tick();
    d_rready = 0;
    #1 chk("er_idle", 32'(grant), 32'h0);

    // IFU access in the UART window is a decode error
    i_arvalid = 1; i_araddr = 32'ha000_03fc;
    tick();
    #1 chk("ie_u_arvalid", 32'(u_arvalid), 32'h0);
    chk("ie_i_arready", 32'(i_arready), 32'h1);
    tick();
    i_arvalid = 0; i_rready = 1;
    #1 chk("ie_i_rresp", 32'(i_rresp), 32'h3);
    chk("ie_i_rvalid", 32'(i_rvalid), 32'h1);
    tick();
    i_rready = 0;

    // Reset during WR_RESP abandons the write
    d_awvalid = 1; d_awaddr = 32'h8000_0010; d_wvalid = 1; d_wdata = 32'h55; d_wstrb = 4'hf;
    tick();
    #1 chk("rw_s_awvalid", 32'(s_awvalid), 32'h1);
    s_awready = 1; s_wready = 1;
    tick();
    d_awvalid = 0; d_wvalid = 0; s_awready = 0; s_wready = 0; d_bready = 1;
    #1 chk("rw_in_resp", 32'(s_bready), 32'h1);
    reset = 1;
    tick();
    reset = 0;
    #1 chk("rw_rst_grant", 32'(grant), 32'h0);
    chk("rw_rst_s_bready", 32'(s_bready), 32'h0);
    chk("rw_rst_d_bvalid", 32'(d_bvalid), 32'h0);
    d_bready = 0;
    i_arvalid = 1; i_araddr = 32'h8000_0020;
    tick();
    #1 chk("rw_ifu_grant", 32'(grant), 32'h1);
    chk("rw_ifu_s_arvalid", 32'(s_arvalid), 32'h1);
    s_arready = 1;
    tick();
    i_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_1234; i_rready = 1;
    #1 chk("rw_ifu_rdata", i_rdata, 32'h0000_1234);
    tick();
    s_rvalid = 0; i_rready = 0;
    #1 chk("rw_ifu_idle", 32'(grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060184_bus_arbiter.md
YSYX_23060184_BUS_ARBITER -- requirements
Module: ysyx_23060184_bus_arbiter

Interface
REQ-001 Parameter UART_BASE, default 32'ha000_03f8, first UART byte address.
REQ-002 Parameter UART_SIZE, default 32'h8, UART window length in bytes.
REQ-003 Parameter DATA_WIDTH, default 32, address/data width.
REQ-004 Clock and reset SHALL be: one clock, `clk`; reset `reset` is synchronous and active-high.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_araddr/i_arvalid/i_arready  in/in/out  32/1/1  IFU read-address channel
- i_rdata/i_rresp/i_rvalid/i_rready  out/out/out/in  32/2/1/1  IFU read-data channel
- d_araddr/d_arvalid/d_arready  in/in/out  32/1/1  LSU read-address channel
- d_rdata/d_rresp/d_rvalid/d_rready  out/out/out/in  32/2/1/1  LSU read-data channel
- d_awaddr/d_awvalid/d_awready, d_wdata/d_wstrb/d_wvalid/d_wready  in,in,out / in,in,in,out  32,1,1 / 32,4,1,1  LSU write address/data
- d_bresp/d_bvalid/d_bready  out/out/in  2/1/1  LSU write response
- s_* / u_*  mixed  as above  downstream AXI4-lite ports to SRAM and UART, full ar/r/aw/w/b sets
- grant  out  2  one-hot current owner, {LSU, IFU}

Function
REQ-006 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, ERR_RESP.
REQ-007 In IDLE, requests SHALL be i_arvalid, d_arvalid and (d_awvalid and d_wvalid); LSU read and LSU write SHALL count as one LSU request, with write taking priority.
REQ-008 Arbitration between IFU and LSU SHALL be round-robin: if both request, grant the master not granted last; the first conflict after reset grants LSU.
REQ-009 The grant SHALL be registered on the IDLE exit edge and held until the response handshake completes; grant SHALL be 2'b00 in IDLE.
REQ-010 Decode: addr in [UART_BASE, UART_BASE+UART_SIZE) selects UART; addr in [32'h8000_0000, 32'h8800_0000) selects SRAM; any other addr goes to ERR_RESP.
REQ-011 IFU addresses SHALL never select UART; an IFU hit in the UART window goes to ERR_RESP.
REQ-012 RD_ADDR: forward the owner's ar* to the selected slave only; the owner's arready SHALL equal the slave arready; on handshake go to RD_DATA.
REQ-013 RD_DATA: route the selected slave r* to the owner and the owner's rready back; on rvalid&&rready go to IDLE.
REQ-014 WR_ADDR: assert awvalid and wvalid to the slave together; each stays asserted until its own handshake; once both have completed, go to WR_RESP.
REQ-015 WR_RESP: route b*; on bvalid&&bready go to IDLE.
REQ-016 ERR_RESP: accept the address (ready=1 for one cycle), then drive rresp/bresp=2'b11 (DECERR) with rvalid/bvalid=1 and rdata=0 until the owner accepts, then go to IDLE.
REQ-017 Non-selected slave valids and non-owner readies/valids SHALL be 0 in every state.
REQ-018 Minimum latency SHALL be request in IDLE to slave valid in 1 cycle; back-to-back transactions SHALL spend at least one cycle in IDLE.
REQ-019 A master dropping valid before handshake is a protocol violation; behaviour is unspecified, but the FSM SHALL not deadlock after reset.

Reset
REQ-020 Reset SHALL force IDLE, grant=0, all outputs 0 and last-grant=IFU (so the next conflict goes to LSU); a reset mid-transaction SHALL abandon it with no response.

Structure
REQ-021 State encoding, resp codes (OKAY=2'b00, DECERR=2'b11), SRAM base/limit and grant indices SHALL live in the shared config/package header.
REQ-022 One sub-module, ysyx_23060184_addr_decode (combinational addr -> {sram, uart, err}), SHALL be instantiated twice (read and write address).

Verification
REQ-023 IFU read at 32'h8000_0000, SRAM rdata=32'h0000_0413 -> grant=01, i_rdata=32'h0000_0413, i_rresp=00, then IDLE.
REQ-024 IFU and LSU reads asserted in the same cycle after reset -> LSU served first, then IFU; repeated conflicts alternate.
REQ-025 LSU write to 32'ha000_03f8, wdata=32'h41, wstrb=4'b0001 -> only u_awvalid/u_wvalid assert, s_* stay 0, and d_bresp=00.
REQ-026 LSU read at 32'h0000_1000 -> no slave valid asserts, d_rresp=2'b11, d_rdata=0.
REQ-027 SRAM holds rvalid for 3 cycles with d_rready=0 -> FSM stays in RD_DATA, and the pending IFU request is not granted until acceptance.
REQ-028 Reset asserted while in WR_RESP -> next cycle in IDLE with all outputs 0, and a new IFU read completes normally.
